// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, ID/EX register layout and opcode encoding for the operand
// fetch stage and the SIMD execute unit that consumes its output.
package operand_fetch_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OPC_W  = 6;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD   = 6'd0,
    OPC_SUB   = 6'd1,
    OPC_MUL   = 6'd2,
    OPC_AND   = 6'd3,
    OPC_OR    = 6'd4,
    OPC_XOR   = 6'd5,
    OPC_LOAD  = 6'd6,
    OPC_STORE = 6'd7
  } opc_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              rd_we;
    logic              is_load;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } idex_t;

endpackage

// File: rtl/operand_fetch_stage_bypass.sv
// Resolves one source operand: EX result first, then the same-cycle register
// file write, otherwise the register file read data.
module operand_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);

  logic ex_hit;
  logic wb_hit;

  // A load in EX has no data yet; that case is a stall, never a forward.
  assign ex_hit = ex_valid & ex_we & ~ex_is_load & (ex_rd == rs);
  assign wb_hit = wb_we & (wb_addr == rs);

  always_comb begin
    operand = rf_rdata;
    if (ex_hit)
      operand = ex_data;
    else if (wb_hit)
      operand = wb_data;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: drives register file reads, forwards from EX/WB,
// stalls on load-use and holds the resolved instruction in the ID/EX register.
module operand_fetch_stage #(
  parameter int DATA_W = operand_fetch_stage_pkg::DATA_W,
  parameter int ADDR_W = operand_fetch_stage_pkg::ADDR_W,
  parameter int OPC_W  = operand_fetch_stage_pkg::OPC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [DATA_W-1:0] out_imm,
  output logic [CNT_W-1:0]  stall_count
);

  import operand_fetch_stage_pkg::*;

  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  idex_t             idex;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // Every address compares in full; r0 is an ordinary register here.
  assign hazard = in_valid & ex_valid & ex_we & ex_is_load &
                  ((ex_rd == in_rs1) | (ex_rd == in_rs2));
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_a (
    .rs(in_rs1), .rf_rdata(rf_rdata1),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .operand(op_a)
  );

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_b (
    .rs(in_rs2), .rf_rdata(rf_rdata2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .operand(op_b)
  );

  // out_valid is the whole EMPTY/FULL state; operands are resolved only here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      idex      <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      idex.rd      <= in_rd;
      idex.rd_we   <= in_rd_we;
      idex.is_load <= in_is_load;
      idex.opcode  <= in_opcode;
      idex.imm     <= in_imm;
      idex.op_a    <= op_a;
      idex.op_b    <= op_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (hazard && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

  assign out_op_a    = idex.op_a;
  assign out_op_b    = idex.op_b;
  assign out_rd      = idex.rd;
  assign out_rd_we   = idex.rd_we;
  assign out_is_load = idex.is_load;
  assign out_opcode  = idex.opcode;
  assign out_imm     = idex.imm;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: stimulus pushes expected ID/EX
// contents into a queue, a negedge monitor pops and compares on each transfer.
module tb_operand_fetch_stage;

  import operand_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, s_in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we, in_is_load;
  logic [5:0]  in_opcode;
  logic [31:0] in_imm;
  logic [4:0]  rf_raddr1, rf_raddr2, s_raddr1, s_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_valid, ex_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready, s_out_valid;
  logic [31:0] out_op_a, out_op_b, out_imm, s_op_a, s_op_b, s_imm;
  logic [4:0]  out_rd, s_rd;
  logic        out_rd_we, out_is_load, s_rd_we, s_is_load;
  logic [5:0]  out_opcode, s_opcode;
  logic [15:0] stall_count;
  logic [1:0]  s_stall_count;

  logic [31:0] rf [32];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
  } exp_t;
  exp_t expq[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) if (wb_we) rf[wb_addr] <= wb_data;

  operand_fetch_stage u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .in_opcode(in_opcode), .in_imm(in_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .out_opcode(out_opcode), .out_imm(out_imm), .stall_count(stall_count)
  );

  // Narrow-counter copy, driven identically, for the saturation check.
  operand_fetch_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .in_opcode(in_opcode), .in_imm(in_imm),
    .rf_raddr1(s_raddr1), .rf_raddr2(s_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_op_a(s_op_a), .out_op_b(s_op_b), .out_rd(s_rd),
    .out_rd_we(s_rd_we), .out_is_load(s_is_load),
    .out_opcode(s_opcode), .out_imm(s_imm), .stall_count(s_stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_output", 32'(out_rd), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        $display("[%0t] pop rd=%0d op_a=0x%0h op_b=0x%0h imm=0x%0h", $time,
                 out_rd, out_op_a, out_op_b, out_imm);
        check("op_a", out_op_a, e.a);
        check("op_b", out_op_b, e.b);
        check("imm", out_imm, e.imm);
        check("rd", 32'(out_rd), 32'(e.rd));
      end
    end
  end

  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_we = 1'b1; in_is_load = 1'b0; in_opcode = OPC_ADD; in_imm = imm;
    e.a = ea; e.b = eb; e.imm = imm; e.rd = rd;
    expq.push_back(e);
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [31:0] ea, input logic [31:0] eb);
    int n;
    present(rs1, rs2, rd, imm, ea, eb);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] <= 32'(i) << 8;
    rf[3] <= 32'h11;
    rf[7] <= 32'h0;
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd5; in_rd = 5'd1;
    in_rd_we = 1'b1; in_is_load = 1'b0; in_opcode = OPC_ADD; in_imm = 32'h1234;
    ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_data = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    // 1: reset, then first accept with one-cycle latency
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_stall_count", 32'(stall_count), 32'd0);
    check("reset_op_a", out_op_a, 32'd0);
    check("reset_rd", 32'(out_rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(5'd3, 5'd5, 5'd1, 32'h1234, 32'h11, 32'h500);
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    idle(2);

    // 2: EX bypass beats WB bypass on the same register
    ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd4; ex_data = 32'hAA;
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hBB;
    issue(5'd1, 5'd4, 5'd2, 32'h2, 32'h100, 32'hAA);
    ex_valid = 1'b0; wb_we = 1'b0;
    idle(2);

    // 3: WB same-cycle write visible through the bypass
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    issue(5'd7, 5'd0, 5'd3, 32'h3, 32'h55, 32'h0);
    wb_we = 1'b0;
    idle(2);

    // 4: load-use stall for three cycles
    ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2; ex_data = 32'hDEAD;
    present(5'd2, 5'd9, 5'd4, 32'h4, 32'h200, 32'h900);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("loaduse_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    @(negedge clk);
    check("loaduse_stall_count", 32'(stall_count), 32'd3);
    check("loaduse_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // 5: back-pressure holds outputs even while WB rewrites the source
    out_ready = 1'b0;
    issue(5'd10, 5'd11, 5'd5, 32'h5, 32'hA00, 32'hB00);
    present(5'd10, 5'd12, 5'd6, 32'h6, 32'h77, 32'hC00);
    wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h77;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_op_a", out_op_a, 32'hA00);
      check("bp_hold_op_b", out_op_b, 32'hB00);
      @(posedge clk); #1;
    end
    wb_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_no_bubble", 32'(out_valid), 32'd1);
    idle(2);

    // 6: hazard on r0 for five cycles; 2-bit counter saturates at 3
    ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
    present(5'd5, 5'd0, 5'd7, 32'h7, 32'h500, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("r0_hazard_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    @(negedge clk);
    check("sat_stall_count", 32'(s_stall_count), 32'd3);
    check("wide_stall_count", 32'(stall_count), 32'd8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(3);

    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
